// File: rtl/rs_degree_pkg.sv
// Shared node record and width helpers for the RS polynomial degree pipeline.
// Optional macro RS_DEGREE_LEAD_EN adds the leading-coefficient field to every node.
package rs_degree_pkg;

    localparam int MAX_NUM_COEF = 64;
    localparam int MAX_DEG_W    = 6;
    localparam int MAX_SYM_W    = 32;

    function automatic int deg_width(input int num_coef);
        return $clog2(num_coef);
    endfunction

    // The merge tree is a full binary tree, so the leaf row is padded to a power of two
    function automatic int pad_width(input int num_coef);
        return 1 << deg_width(num_coef);
    endfunction

    typedef struct packed {
        logic                 nz;
        logic [MAX_DEG_W-1:0] idx;
`ifdef RS_DEGREE_LEAD_EN
        logic [MAX_SYM_W-1:0] lead;
`endif
    } node_t;

endpackage

// File: rtl/rs_degree_merge.sv
// Combinational merge of two degree-tree nodes; the higher-index nonzero node wins.
// Node contents depend on RS_DEGREE_LEAD_EN through rs_degree_pkg::node_t.
module rs_degree_merge
    import rs_degree_pkg::*;
(
    input  node_t lo,
    input  node_t hi,
    output node_t merged
);

    always_comb begin
        merged    = hi.nz ? hi : lo;
        merged.nz = lo.nz | hi.nz;
    end

endmodule

// File: rtl/rs_degree_pipe.sv
// Pipelined degree evaluator: stage 0 registers the vector, then one registered merge level per index bit.
// Define RS_DEGREE_LEAD_EN to also return the leading coefficient on out_lead.
module rs_degree_pipe
    import rs_degree_pkg::*;
#(
    parameter  int NUM_COEF = 9,
    parameter  int SYM_W    = 8,
    parameter  int TAG_W    = 4,
    localparam int DEG_W    = deg_width(NUM_COEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_COEF*SYM_W-1:0] in_coef,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DEG_W-1:0]          out_degree,
    output logic                      out_zero,
`ifdef RS_DEGREE_LEAD_EN
    output logic [SYM_W-1:0]          out_lead,
`endif
    output logic [TAG_W-1:0]          out_tag
);

    localparam int P     = pad_width(NUM_COEF);
    localparam int NODES = P - 1;

    if (NUM_COEF < 2 || NUM_COEF > MAX_NUM_COEF) begin : g_bad_num_coef
        $error("rs_degree_pipe: NUM_COEF must lie in 2..64");
    end
    if (SYM_W < 1 || SYM_W > MAX_SYM_W) begin : g_bad_sym_w
        $error("rs_degree_pipe: SYM_W must lie in 1..32");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("rs_degree_pipe: TAG_W must be at least 1");
    end

    function automatic node_t make_leaf(input logic [SYM_W-1:0] c, input int i);
        node_t n;
        n     = '0;
        n.nz  = |c;
        n.idx = MAX_DEG_W'(i);
`ifdef RS_DEGREE_LEAD_EN
        n.lead = MAX_SYM_W'(c);
`endif
        return n;
    endfunction

    logic                      stall;
    logic [DEG_W:0]            vld_q;
    logic [TAG_W-1:0]          tag_q  [0:DEG_W];
    logic [NUM_COEF*SYM_W-1:0] coef_q;
    node_t                     node_q [0:NODES-1];
    node_t                     node_d [0:NODES-1];
    node_t                     tree   [0:2*P-2];
    node_t                     root;

    // Heap layout: entries below NODES are registered merge results, the rest are leaves from stage 0
    for (genvar h = 0; h < 2*P-1; h++) begin : g_tree
        if (h < NODES) begin : g_reg
            assign tree[h] = node_q[h];
        end else if (h - NODES < NUM_COEF) begin : g_leaf
            assign tree[h] = make_leaf(coef_q[(h-NODES)*SYM_W +: SYM_W], h - NODES);
        end else begin : g_pad
            assign tree[h] = '0;
        end
    end

    for (genvar n = 0; n < NODES; n++) begin : g_merge
        rs_degree_merge u_merge (
            .lo     (tree[2*n+1]),
            .hi     (tree[2*n+2]),
            .merged (node_d[n])
        );
    end

    assign stall    = vld_q[DEG_W] && !out_ready;
    assign in_ready = !stall;

    // Whole pipeline advances together or freezes together; reset beats stall
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            coef_q <= '0;
            for (int l = 0; l <= DEG_W; l++) tag_q[l] <= '0;
            for (int n = 0; n < NODES; n++) node_q[n] <= '0;
        end else if (!stall) begin
            vld_q    <= {vld_q[DEG_W-1:0], in_valid};
            coef_q   <= in_coef;
            tag_q[0] <= in_tag;
            for (int l = 1; l <= DEG_W; l++) tag_q[l] <= tag_q[l-1];
            for (int n = 0; n < NODES; n++) node_q[n] <= node_d[n];
        end
    end

    assign root       = node_q[0];
    assign out_valid  = vld_q[DEG_W];
    assign out_zero   = !root.nz;
    assign out_degree = root.nz ? root.idx[DEG_W-1:0] : '0;
    assign out_tag    = tag_q[DEG_W];
`ifdef RS_DEGREE_LEAD_EN
    assign out_lead   = root.nz ? root.lead[SYM_W-1:0] : '0;
`endif

endmodule

// File: tb/tb_rs_degree_pipe.sv
// Self-checking bench for rs_degree_pipe: default and 17x10 instances against a scan-based reference model.
// Lead checks are compiled in when RS_DEGREE_LEAD_EN is defined.
module tb_rs_degree_pipe;

    localparam int NC   = 9;
    localparam int SW   = 8;
    localparam int TW   = 4;
    localparam int DW   = $clog2(NC);
    localparam int LAT  = DW + 1;
    localparam int NC2  = 17;
    localparam int SW2  = 10;
    localparam int DW2  = $clog2(NC2);
    localparam int LAT2 = DW2 + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [NC*SW-1:0]  in_coef;
    logic [TW-1:0]     in_tag, out_tag;
    logic [DW-1:0]     out_degree;
    logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
    logic [NC2*SW2-1:0] b_in_coef;
    logic [TW-1:0]     b_in_tag, b_out_tag;
    logic [DW2-1:0]    b_out_degree;
`ifdef RS_DEGREE_LEAD_EN
    logic [SW-1:0]     out_lead;
    logic [SW2-1:0]    b_out_lead;
`endif

    rs_degree_pipe #(.NUM_COEF(NC), .SYM_W(SW), .TAG_W(TW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coef    (in_coef),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_degree (out_degree),
        .out_zero   (out_zero),
`ifdef RS_DEGREE_LEAD_EN
        .out_lead   (out_lead),
`endif
        .out_tag    (out_tag)
    );

    rs_degree_pipe #(.NUM_COEF(NC2), .SYM_W(SW2), .TAG_W(TW)) u_dut_wide (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_coef    (b_in_coef),
        .in_tag     (b_in_tag),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_degree (b_out_degree),
        .out_zero   (b_out_zero),
`ifdef RS_DEGREE_LEAD_EN
        .out_lead   (b_out_lead),
`endif
        .out_tag    (b_out_tag)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    // Reference: scan every coefficient upward, the last nonzero one seen is the degree
    function automatic void refDegree(input logic [1023:0] v, input int n, input int w,
                                      output int deg, output bit zero, output logic [31:0] lead);
        logic [31:0] c;
        deg  = 0;
        zero = 1'b1;
        lead = '0;
        for (int i = 0; i < n; i++) begin
            c = 32'((v >> (i*w)) & ((1024'(1) << w) - 1));
            if (c != 0) begin
                deg  = i;
                zero = 1'b0;
                lead = c;
            end
        end
    endfunction

    function automatic logic [1023:0] randVector(input int n, input int w);
        logic [1023:0] v;
        int            d;
        logic [31:0]   c;
        v = '0;
        d = $urandom_range(0, n);
        for (int i = 0; i < d; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & ((32'd1 << w) - 1));
            v = v | (1024'(c) << (i*w));
        end
        if (d < n) begin
            c = ($urandom % ((32'd1 << w) - 1)) + 1;
            v = v | (1024'(c) << (d*w));
        end
        return v;
    endfunction

    typedef struct {
        logic [TW-1:0] tag;
        int            degree;
        bit            zero;
        logic [31:0]   lead;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    // Scoreboard: push at acceptance, compare the head while it is presented, pop when consumed
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
        end else begin
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (expq.size() == 0) begin
                checkOutput("no_spurious", out_valid, 1'b0);
            end else if (out_valid) begin
                mon_e = expq[0];
                checkOutput("tag", out_tag, mon_e.tag);
                checkOutput("degree", out_degree, mon_e.degree);
                checkOutput("zero", out_zero, mon_e.zero);
`ifdef RS_DEGREE_LEAD_EN
                checkOutput("lead", out_lead, mon_e.lead);
`endif
                if (out_ready) void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                refDegree(1024'(in_coef), NC, SW, mon_e.degree, mon_e.zero, mon_e.lead);
                mon_e.tag = in_tag;
                expq.push_back(mon_e);
            end
        end
    end

    task automatic applyStimulus(input logic [NC*SW-1:0] v, input logic [TW-1:0] t);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_coef  = v;
        in_tag   = t;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", accepted, 1'b1);
    endtask

    task automatic directedCase(input string name, input logic [NC*SW-1:0] v, input logic [TW-1:0] t,
                                input int deg, input bit zero, input logic [31:0] lead);
        int n;
        in_valid = 1'b1;
        in_coef  = v;
        in_tag   = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_latency"}, n, LAT);
        checkOutput({name, "_degree"}, out_degree, deg);
        checkOutput({name, "_zero"}, out_zero, zero);
        checkOutput({name, "_tag"}, out_tag, t);
`ifdef RS_DEGREE_LEAD_EN
        checkOutput({name, "_lead"}, out_lead, lead);
`else
        if (lead != lead) checkOutput({name, "_lead"}, lead, 0);
`endif
    endtask

    task automatic wideCase(input string name, input logic [NC2*SW2-1:0] v, input logic [TW-1:0] t,
                            input int deg, input bit zero, input logic [31:0] lead);
        int n;
        b_in_valid = 1'b1;
        b_in_coef  = v;
        b_in_tag   = t;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_latency"}, n, LAT2);
        checkOutput({name, "_degree"}, b_out_degree, deg);
        checkOutput({name, "_zero"}, b_out_zero, zero);
        checkOutput({name, "_tag"}, b_out_tag, t);
`ifdef RS_DEGREE_LEAD_EN
        checkOutput({name, "_lead"}, b_out_lead, lead);
`else
        if (lead != lead) checkOutput({name, "_lead"}, lead, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        for (int k = 0; k < 200 && expq.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, expq.size(), 0);
    endtask

    logic [NC*SW-1:0]   v;
    logic [NC2*SW2-1:0] bv;
    int                 stallSeen;
    int                 seen;
    int                 rd;
    bit                 rz;
    logic [31:0]        rl;

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_coef     = randVector(NC, SW)[NC*SW-1:0];
        in_tag      = 4'hA;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_coef   = '0;
        b_in_tag    = '0;
        b_out_ready = 1'b1;

        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("rst_out_valid", out_valid, 1'b0);
            checkOutput("rst_out_zero", out_zero, 1'b1);
            checkOutput("rst_out_degree", out_degree, 0);
            checkOutput("rst_out_tag", out_tag, 0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", in_ready, 1'b1);

        v = '0; v[0 +: SW] = 8'h01; v[3*SW +: SW] = 8'h5A;
        directedCase("c3", v, 4'd1, 3, 1'b0, 32'h5A);
        v = '0;
        directedCase("all_zero", v, 4'd2, 0, 1'b1, 32'h0);
        v = '0; v[8*SW +: SW] = 8'hFF;
        directedCase("c8", v, 4'd3, 8, 1'b0, 32'hFF);
        v = '0; v[0 +: SW] = 8'h07;
        directedCase("c0", v, 4'd4, 0, 1'b0, 32'h07);
        @(posedge clk);
        #1;
        waitDrain("drain_directed");

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 20; i++) begin
            v = randVector(NC, SW)[NC*SW-1:0];
            applyStimulus(v, TW'(i));
        end
        in_valid = 1'b0;
        waitDrain("drain_stream");

        $display("[TB] backpressure");
        stallSeen = 0;
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    v = randVector(NC, SW)[NC*SW-1:0];
                    applyStimulus(v, TW'(i + 3));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!in_ready) stallSeen++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        checkOutput("stall_cycles", stallSeen, 4);
        waitDrain("drain_backpressure");

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            v = randVector(NC, SW)[NC*SW-1:0];
            v[0 +: SW] = 8'h11;
            applyStimulus(v, TW'(i + 8));
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("reset_drop", seen, 0);
        v = '0; v[2*SW +: SW] = 8'h80; v[5*SW +: SW] = 8'h33;
        directedCase("post_reset", v, 4'd9, 5, 1'b0, 32'h33);
        @(posedge clk);
        #1;
        waitDrain("drain_post_reset");

        $display("[TB] wide instance");
        bv = '0; bv[16*SW2 +: SW2] = 10'h3FF;
        wideCase("w_c16", bv, 4'd5, 16, 1'b0, 32'h3FF);
        bv = '0;
        wideCase("w_zero", bv, 4'd6, 0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bv = randVector(NC2, SW2)[NC2*SW2-1:0];
            refDegree(1024'(bv), NC2, SW2, rd, rz, rl);
            wideCase("w_rand", bv, TW'(i), rd, rz, rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
